// File: rtl/async_event_pkg.sv
// Shared constants and helpers for the async event arbiter family.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
//
// Contents:
//   SYNC_DEPTH_MIN  - fewest synchronizer flops accepted per async input
//   CHANNELS_MIN/MAX - legal range for the channel count
//   clog2_min1(n)   - index width for n items, never less than one bit
package async_event_pkg;

  localparam int SYNC_DEPTH_MIN = 2;
  localparam int CHANNELS_MIN   = 1;
  localparam int CHANNELS_MAX   = 32;

  // A single channel still needs a 1-bit index port, so $clog2(1)=0 is
  // bumped up to 1.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request strictly after 'last', wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides whether the pick is consumed.
//
// Ports:
//   req  [N]  request vector
//   last [W]  index granted most recently (search starts at last+1)
//   any       at least one request is set
//   sel  [W]  chosen index, 0 when nothing is requested
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         any,
  output logic [W-1:0] sel
);

  int idx;

  // Walk offsets 1..N so 'last' itself is visited only after every other
  // channel; the first hit wins and later hits are ignored.
  always_comb begin
    any = 1'b0;
    sel = '0;
    idx = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last) + off) % N;
      if (!any && req[idx]) begin
        any = 1'b1;
        sel = W'(idx);
      end
    end
  end

endmodule

// File: rtl/async_event_arbiter.sv
// Synchronizes async level inputs, latches rising edges as pending events and
// serializes them round-robin onto one valid/ready stream of channel indices.
// Latency: input edge to m_event_valid is SYNC_DEPTH+1 clocks when idle.
// Backpressure: valid/channel hold while !ready; further edges stay pending.
//
// Build option: define ASYNC_EVENT_ARBITER_OVERFLOW_EN to get sticky per-channel
// lost-event flags on 'overflow'; without it 'overflow' is tied to zero.
//
// Ports:
//   clk              system clock
//   rst              synchronous reset, active high
//   async_in         [CHANNELS] asynchronous levels, rising edge = one event
//   m_event_valid    event present on m_event_channel
//   m_event_ready    consumer accepts (transfer = valid && ready)
//   m_event_channel  [CH_W] index of the channel that produced the event
//   pending          [CHANNELS] registered per-channel pending flags
//   overflow         [CHANNELS] sticky lost-event flags
module async_event_arbiter
  import async_event_pkg::*;
#(
  parameter  int CHANNELS   = 4,
  parameter  int SYNC_DEPTH = 2,
  localparam int CH_W       = clog2_min1(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] async_in,
  output logic                m_event_valid,
  input  logic                m_event_ready,
  output logic [CH_W-1:0]     m_event_channel,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] overflow
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  generate
    if (SYNC_DEPTH < SYNC_DEPTH_MIN) begin : g_bad_sync_depth
      $error("async_event_arbiter: SYNC_DEPTH must be at least %0d", SYNC_DEPTH_MIN);
    end
    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
      $error("async_event_arbiter: CHANNELS must be in %0d..%0d", CHANNELS_MIN, CHANNELS_MAX);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Synchronizer chain. No reset: these flops must be free of any logic so
  // the tools can place them adjacently for metastability settling.
  // ---------------------------------------------------------------------------
  (* async_reg = "true" *) logic [CHANNELS-1:0] sync_ff [SYNC_DEPTH];

  always_ff @(posedge clk) begin
    sync_ff[0] <= async_in;
    for (int s = 1; s < SYNC_DEPTH; s++) begin
      sync_ff[s] <= sync_ff[s-1];
    end
  end

  logic [CHANNELS-1:0] sync_q;
  assign sync_q = sync_ff[SYNC_DEPTH-1];

  // ---------------------------------------------------------------------------
  // Edge detect. prev_q keeps tracking during rst so a level that is already
  // high when reset releases is treated as old news, not a fresh edge.
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] rise;

  always_ff @(posedge clk) begin
    prev_q <= sync_q;
  end

  assign rise = sync_q & ~prev_q & {CHANNELS{~rst}};

  // ---------------------------------------------------------------------------
  // Arbitration over registered pending only; a rise this cycle competes next
  // cycle.
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0]     last_grant;
  logic                pick_any;
  logic [CH_W-1:0]     pick_sel;
  logic                load_en;
  logic                load_take;
  logic [CHANNELS-1:0] load_mask;
  logic [CHANNELS-1:0] pending_nxt;

  rr_pick #(
    .N (CHANNELS),
    .W (CH_W)
  ) u_rr_pick (
    .req  (pending),
    .last (last_grant),
    .any  (pick_any),
    .sel  (pick_sel)
  );

  // The output register is free when empty or being drained this cycle.
  assign load_en   = !m_event_valid || m_event_ready;
  assign load_take = load_en && pick_any;
  assign load_mask = load_take ? (CHANNELS'(1) << pick_sel) : '0;

  // Rise wins over the clear: a new edge on a channel being loaded replaces
  // the consumed event instead of vanishing.
  assign pending_nxt = (pending & ~load_mask) | rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending         <= '0;
      m_event_valid   <= 1'b0;
      m_event_channel <= '0;
      last_grant      <= CH_W'(CHANNELS - 1);
    end else begin
      pending <= pending_nxt;
      if (load_en) begin
        if (pick_any) begin
          m_event_valid   <= 1'b1;
          m_event_channel <= pick_sel;
          last_grant      <= pick_sel;
        end else begin
          // Nothing to offer: drop valid, keep channel and pointer as they are.
          m_event_valid <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lost-event tracking
  // ---------------------------------------------------------------------------
`ifdef ASYNC_EVENT_ARBITER_OVERFLOW_EN
  logic [CHANNELS-1:0] overflow_q;
  logic [CHANNELS-1:0] lost;

  // An edge is lost only when the channel already holds an unserved event
  // that is not being moved into the output register this same cycle.
  assign lost = rise & pending & ~load_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= '0;
    end else begin
      overflow_q <= overflow_q | lost;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = '0;
`endif

  // ---------------------------------------------------------------------------
  // Interface invariant: a stalled event must not change under the consumer.
  // ---------------------------------------------------------------------------
  a_hold_while_stalled : assert property (
    @(posedge clk) disable iff (rst)
      (m_event_valid && !m_event_ready) |=> (m_event_valid && $stable(m_event_channel))
  );

endmodule

// File: tb/tb_async_event_arbiter.sv
// Self-checking bench for async_event_arbiter (CHANNELS=4, SYNC_DEPTH=2).
// Directed vector table, hand-written corner sequences, then random stimulus
// compared every cycle against a behavioural model of the event rules.
module tb_async_event_arbiter;

  localparam int C = 4;
  localparam int D = 2;
`ifdef ASYNC_EVENT_ARBITER_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [C-1:0] async_in;
  logic         m_event_valid;
  logic         m_event_ready;
  logic [1:0]   m_event_channel;
  logic [C-1:0] pending;
  logic [C-1:0] overflow;

  async_event_arbiter #(
    .CHANNELS   (C),
    .SYNC_DEPTH (D)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .async_in        (async_in),
    .m_event_valid   (m_event_valid),
    .m_event_ready   (m_event_ready),
    .m_event_channel (m_event_channel),
    .pending         (pending),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. hist holds the last D+1 sampled input words, oldest
  // first; an event is recognised D edges after its first sample.
  // ---------------------------------------------------------------------------
  logic [C-1:0] hist[$];
  logic         mv;
  int           mch;
  logic [C-1:0] mp;
  logic [C-1:0] mo;
  int           mlast;

  task automatic model_step(input logic [C-1:0] a, input logic rd, input logic r);
    logic [C-1:0] ev;
    int picked;
    ev = r ? '0 : (hist[1] & ~hist[0]);
    hist.push_back(a);
    void'(hist.pop_front());
    if (r) begin
      mv = 1'b0; mch = 0; mp = '0; mo = '0; mlast = C - 1;
    end else begin
      picked = -1;
      if (!mv || rd) begin
        for (int k = 1; k <= C; k++) begin
          if (picked < 0 && mp[(mlast + k) % C]) picked = (mlast + k) % C;
        end
        if (picked >= 0) begin
          mv = 1'b1; mch = picked; mlast = picked;
        end else begin
          mv = 1'b0;
        end
      end
      for (int i = 0; i < C; i++) begin
        if (OVF_EN && ev[i] && mp[i] && i != picked) mo[i] = 1'b1;
        mp[i] = (mp[i] && i != picked) || ev[i];
      end
    end
  endtask

  task automatic check_model();
    check("model_valid",    32'(m_event_valid),   32'(mv));
    check("model_channel",  32'(m_event_channel), 32'(mch));
    check("model_pending",  32'(pending),         32'(mp));
    check("model_overflow", 32'(overflow),        32'(mo));
  endtask

  int xfer_q[$];

  // One clock: record a transfer that the coming edge will perform, drive the
  // inputs, advance the model, then check on the falling edge.
  task automatic cycle(input logic [C-1:0] a, input logic rd, input logic r);
    if (m_event_valid && rd && !r) xfer_q.push_back(int'(m_event_channel));
    async_in      = a;
    m_event_ready = rd;
    rst           = r;
    model_step(a, rd, r);
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  typedef struct packed {
    logic [C-1:0] a;
    logic         rd;
    logic         v;
    logic [1:0]   ch;
    logic [C-1:0] p;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  int n_valid;
  int n_ch2;
  int exp_ch;
  logic [C-1:0] ra;

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i <= D; i++) hist.push_back('0);
    mv = 1'b0; mch = 0; mp = '0; mo = '0; mlast = C - 1;
    async_in = '0; m_event_ready = 1'b0; rst = 1'b1;

    // Fresh reset, then simultaneous ch0/ch2, single ch1 edge, ch3 stalled.
    tbl[0]  = '{4'b0101, 1'b1, 1'b0, 2'd0, 4'b0000};
    tbl[1]  = '{4'b0101, 1'b1, 1'b0, 2'd0, 4'b0000};
    tbl[2]  = '{4'b0101, 1'b1, 1'b0, 2'd0, 4'b0101};
    tbl[3]  = '{4'b0101, 1'b1, 1'b1, 2'd0, 4'b0100};
    tbl[4]  = '{4'b0101, 1'b1, 1'b1, 2'd2, 4'b0000};
    tbl[5]  = '{4'b0101, 1'b1, 1'b0, 2'd2, 4'b0000};
    tbl[6]  = '{4'b0111, 1'b1, 1'b0, 2'd2, 4'b0000};
    tbl[7]  = '{4'b0111, 1'b1, 1'b0, 2'd2, 4'b0000};
    tbl[8]  = '{4'b0111, 1'b1, 1'b0, 2'd2, 4'b0010};
    tbl[9]  = '{4'b0111, 1'b1, 1'b1, 2'd1, 4'b0000};
    tbl[10] = '{4'b0111, 1'b1, 1'b0, 2'd1, 4'b0000};
    tbl[11] = '{4'b0111, 1'b1, 1'b0, 2'd1, 4'b0000};
    tbl[12] = '{4'b1111, 1'b0, 1'b0, 2'd1, 4'b0000};
    tbl[13] = '{4'b1111, 1'b0, 1'b0, 2'd1, 4'b0000};
    tbl[14] = '{4'b1111, 1'b0, 1'b0, 2'd1, 4'b1000};
    for (int i = 15; i < 20; i++) tbl[i] = '{4'b1111, 1'b0, 1'b1, 2'd3, 4'b0000};
    tbl[20] = '{4'b1111, 1'b1, 1'b0, 2'd3, 4'b0000};
    tbl[21] = '{4'b1111, 1'b1, 1'b0, 2'd3, 4'b0000};

    repeat (5) cycle('0, 1'b0, 1'b1);
    check("rst_valid",    32'(m_event_valid),   32'd0);
    check("rst_channel",  32'(m_event_channel), 32'd0);
    check("rst_pending",  32'(pending),         32'd0);
    check("rst_overflow", 32'(overflow),        32'd0);

    for (int i = 0; i < NV; i++) begin
      cycle(tbl[i].a, tbl[i].rd, 1'b0);
      check($sformatf("tbl%0d_valid", i),    32'(m_event_valid),   32'(tbl[i].v));
      check($sformatf("tbl%0d_channel", i),  32'(m_event_channel), 32'(tbl[i].ch));
      check($sformatf("tbl%0d_pending", i),  32'(pending),         32'(tbl[i].p));
      check($sformatf("tbl%0d_overflow", i), 32'(overflow),        32'd0);
    end

    // Fairness: all channels retriggered every 4 cycles, ready held high.
    repeat (3) cycle('0, 1'b1, 1'b1);
    repeat (3) cycle('0, 1'b1, 1'b0);
    xfer_q.delete();
    for (int t = 0; t < 40; t++) cycle((t % 4 < 2) ? 4'hF : 4'h0, 1'b1, 1'b0);
    check("fair_count_ok", 32'(xfer_q.size() >= 32), 32'd1);
    exp_ch = 0;
    foreach (xfer_q[i]) begin
      check($sformatf("fair_seq%0d", i), 32'(xfer_q[i]), 32'(exp_ch));
      exp_ch = (exp_ch + 1) % C;
    end

    // Overflow: ch0 parks in the stalled output, ch2 rises twice behind it.
    repeat (2) cycle('0, 1'b0, 1'b1);
    repeat (3) cycle('0, 1'b0, 1'b0);
    repeat (4) cycle(4'b0001, 1'b0, 1'b0);
    check("ovf_park_valid",   32'(m_event_valid),   32'd1);
    check("ovf_park_channel", 32'(m_event_channel), 32'd0);
    repeat (2) cycle(4'b0101, 1'b0, 1'b0);
    repeat (2) cycle(4'b0001, 1'b0, 1'b0);
    repeat (5) cycle(4'b0101, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'(OVF_EN ? 4'b0100 : 4'b0000));
    xfer_q.delete();
    repeat (6) cycle(4'b0101, 1'b1, 1'b0);
    n_ch2 = 0;
    foreach (xfer_q[i]) if (xfer_q[i] == 2) n_ch2++;
    check("ovf_xfers", 32'(xfer_q.size()), 32'd2);
    check("ovf_ch2_once", 32'(n_ch2), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'(OVF_EN ? 4'b0100 : 4'b0000));
    cycle(4'b0101, 1'b1, 1'b1);
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Reset with an in-flight event and three queued.
    repeat (3) cycle('0, 1'b0, 1'b0);
    repeat (4) cycle(4'b1000, 1'b0, 1'b0);
    check("q3_inflight", 32'(m_event_valid), 32'd1);
    repeat (3) cycle(4'b1111, 1'b0, 1'b0);
    check("q3_pending", 32'(pending), 32'(4'b0111));
    cycle(4'b1111, 1'b0, 1'b1);
    check("q3_rst_valid",   32'(m_event_valid),   32'd0);
    check("q3_rst_channel", 32'(m_event_channel), 32'd0);
    check("q3_rst_pending", 32'(pending),         32'd0);
    xfer_q.delete();
    cycle(4'b1111, 1'b1, 1'b1);
    n_valid = 0;
    for (int t = 0; t < 8; t++) begin
      cycle(4'b1111, 1'b1, 1'b0);
      if (m_event_valid) n_valid++;
    end
    check("held_high_no_event", 32'(n_valid), 32'd0);

    // Levels rise while rst is asserted: still no event after release.
    repeat (4) cycle('0, 1'b1, 1'b0);
    repeat (4) cycle(4'b1111, 1'b1, 1'b1);
    n_valid = 0;
    for (int t = 0; t < 8; t++) begin
      cycle(4'b1111, 1'b1, 1'b0);
      if (m_event_valid) n_valid++;
    end
    check("rise_in_rst_no_event", 32'(n_valid), 32'd0);
    check("no_xfer_after_rst", 32'(xfer_q.size()), 32'd0);

    // Random traffic against the model.
    ra = '0;
    for (int t = 0; t < 3000; t++) begin
      ra = ra ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      cycle(ra, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/async_event_arbiter.md
Name: async_event_arbiter

Overview:
- Collects rising-edge events from CHANNELS asynchronous single-bit inputs.
- Each input passes through its own N-stage synchronizer, is edge-detected and latched as a pending event.
- Pending events are serialized round-robin onto one valid/ready event stream carrying the channel index.
- Sits between board-level async status/interrupt pins and a single-clock event consumer, such as a CSR block or interrupt controller.

Parameters:
- CHANNELS, 4, number of async inputs (1..32).
- SYNC_DEPTH, 2, synchronizer stages per input (>=2).
- CH_W, $clog2(CHANNELS) with minimum 1, channel index width; localparam, not user-set.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- async_in  input  CHANNELS  asynchronous level inputs; a rising edge = one event.
- m_event_valid  output  1  event present on m_event_channel.
- m_event_ready  input  1  consumer accepts; transfer = valid && ready.
- m_event_channel  output  CH_W  index of the channel that produced the event.
- pending  output  CHANNELS  per-channel pending flags (status, registered).
- overflow  output  CHANNELS  sticky lost-event flags; tied to 0 unless the feature is enabled.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high on rst. Already decided.
- Synchronizer: SYNC_DEPTH flops per bit marked async_reg; no reset on these flops. sync_q = last stage.
- Edge detect:
  - prev_q <= sync_q every cycle, including during rst, so a level already high at reset release produces no event.
  - rise[i] = sync_q[i] & ~prev_q[i]; suppressed while rst.
- Reset values: m_event_valid=0, m_event_channel=0, pending=0, overflow=0, round-robin pointer last_grant=CHANNELS-1 (channel 0 has first priority).
- Pending update, per cycle, for channel i:
  - set if rise[i];
  - cleared if i is loaded into the output register this cycle;
  - rise and load on the same cycle → pending stays 1 (new event replaces consumed one);
  - rise while pending[i]=1 and not loaded → event lost; pending stays 1 (see Optional Feature).
- Output register load condition: load_en = !m_event_valid || m_event_ready.
- When load_en is true:
  - any pending: select the first set bit searching from last_grant+1 upward with wrap; set m_event_channel=sel, m_event_valid=1, last_grant=sel, clear pending[sel].
  - none pending: m_event_valid<=0; m_event_channel and last_grant hold.
- Only registered pending is arbitrated; a rise this cycle is eligible next cycle.
- Back-to-back transfers: with ready held high and multiple channels pending, one event per cycle, no bubbles.
- Stability: while valid && !ready, m_event_valid and m_event_channel hold.
- Latency: async_in first sampled high at edge k → sync_q high after edge k+SYNC_DEPTH-1 → pending after edge k+SYNC_DEPTH → m_event_valid after edge k+SYNC_DEPTH+1 (output idle, no contention).
- Reset mid-operation: queued pending and the in-flight event are discarded; no transfer is reported for them.
- Input pulses shorter than one clk period may be missed; this is documented, not detected.

Optional Feature:
- Macro: ASYNC_EVENT_ARBITER_OVERFLOW_EN.
- Defined:
  - overflow[i] sets when rise[i] occurs while pending[i]=1 and channel i is not loaded the same cycle;
  - overflow is sticky, cleared only by rst.
- Undefined: overflow is constant 0 and no overflow flops are generated.

Decomposition:
- Shared package async_event_pkg:
  - function clog2_min1(n) for CH_W;
  - localparam SYNC_DEPTH_MIN = 2 for elaboration checks.
- One sub-module: rr_pick (combinational). Inputs: req[CHANNELS], last[CH_W]. Outputs: any, sel[CH_W]. Reused by future arbiters.
- Synchronizer stages are inline in this block.

Test Plan:
- Single edge, SYNC_DEPTH=2, ready=1: async_in[1] 0→1 → valid for 1 cycle, channel=1, exactly 3 cycles after first sampling edge; no further events while the level stays high.
- Simultaneous edges on ch0 and ch2, ready=1 → channel 0 then channel 2 on consecutive cycles; pending returns to 0.
- Backpressure: ch3 event, ready=0 for 5 cycles → valid/channel=3 held stable; transfer on the first ready cycle; then valid=0.
- Fairness, all 4 channels re-triggered continuously, ready=1 → channel sequence 0,1,2,3,0,1… with no channel repeated before the others are served.
- Overflow (macro defined), ready=0: two rises on ch2 → overflow[2]=1, one ch2 event delivered; overflow stays set until rst. Macro undefined → overflow=0.
- Reset: async_in=4'b1111 held through rst and released → no events. Assert rst with 3 pending → all outputs at reset values next cycle.
